keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces presses and produces the hex key code `n` with a display-enable level `init`. These outputs connect directly to the `n`/`init` inputs of the seven-segment decoder. The block is the producer end of that interface and sits between the board keypad pins and the display path. Each accepted press also generates a one-cycle strobe for downstream logic.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/sync2.sv | 23 ++
 rtl/keypad_scanner.sv | 130 +++++++++++++
 tb/tb_keypad_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  // Hex code per key, indexed [row][col]
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Returns {valid, idx}; valid only when exactly one active-low row is asserted
  function automatic logic [2:0] onehot_low_idx(input logic [3:0] rows);
    logic [2:0] res;
    case (rows)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle pull-up level).
module sync2 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad controller with press/release debounce; emits hex code,
// a sticky display enable and a one-cycle strobe per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] n,
  output logic       init,
  output logic       key_strobe
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  // The capture sample counts as the first match, so acceptance is one match earlier
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CNT - 2);

  logic [3:0]       rs;
  logic [DIV_W-1:0] div;
  logic             sample_c;
  logic [2:0]       hit_c;

  state_e           state, state_nxt;
  logic [1:0]       col_idx, col_nxt;
  logic [1:0]       row_idx, row_nxt;
  logic [3:0]       pattern, pattern_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic [CNT_W-1:0] rel_cnt, rel_nxt;
  logic             accept_c;

  sync2 #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rows),
    .q     (rs)
  );

  assign sample_c = (div == DIV_LAST);
  assign hit_c    = onehot_low_idx(rs);

  // Next-state logic; all decisions happen only at the divider sample point
  always_comb begin
    state_nxt   = state;
    col_nxt     = col_idx;
    row_nxt     = row_idx;
    pattern_nxt = pattern;
    deb_nxt     = deb_cnt;
    rel_nxt     = rel_cnt;
    accept_c    = 1'b0;
    if (sample_c) begin
      case (state)
        SCAN: begin
          if (hit_c[2]) begin
            row_nxt     = hit_c[1:0];
            pattern_nxt = rs;
            deb_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rs == pattern) begin
            deb_nxt = deb_cnt + CNT_W'(1);
            if (deb_cnt == DEB_LAST) begin
              state_nxt = HELD;
              rel_nxt   = '0;
              accept_c  = 1'b1;
            end
          end else begin
            state_nxt = SCAN;
            col_nxt   = col_idx + 2'd1;
          end
        end
        HELD: begin
          if (rs == 4'hF) begin
            if (rel_cnt == REL_LAST) begin
              state_nxt = SCAN;
              col_nxt   = col_idx + 2'd1;
              rel_nxt   = '0;
            end else begin
              rel_nxt = rel_cnt + CNT_W'(1);
            end
          end else begin
            rel_nxt = '0;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN;
      div        <= '0;
      col_idx    <= 2'd0;
      row_idx    <= 2'd0;
      pattern    <= 4'hF;
      deb_cnt    <= '0;
      rel_cnt    <= '0;
      cols       <= 4'b1110;
      n          <= 4'h0;
      init       <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_nxt;
      div        <= sample_c ? '0 : div + DIV_W'(1);
      col_idx    <= col_nxt;
      row_idx    <= row_nxt;
      pattern    <= pattern_nxt;
      deb_cnt    <= deb_nxt;
      rel_cnt    <= rel_nxt;
      cols       <= ~(4'b0001 << col_nxt);
      key_strobe <= accept_c;
      if (accept_c) begin
        n    <= KEYMAP[row_idx][col_idx];
        init <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed table plus corner sequences,
// and randomized presses checked every cycle against a sample-level reference model.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] mask = '0;
  logic [3:0]  rows, cols, n;
  logic        init, key_strobe;

  int vec = 0;
  int errs = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows       (rows),
    .cols       (cols),
    .n          (n),
    .init       (init),
    .key_strobe (key_strobe)
  );

  // Reference model state
  int         km [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [3:0] h0, h1, pat;
  int         cyc, mcol, mode, run, quiet;
  logic [3:0] exp_cols, exp_n;
  logic       exp_init, exp_strobe;

  typedef struct {
    logic [15:0] mask;
    int          cycles;
    logic [3:0]  n;
    logic        init;
    int          strobes;
    logic [3:0]  cols;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int low_row(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    h0 = 4'hF; h1 = 4'hF; pat = 4'hF;
    cyc = 0; mcol = 0; mode = 0; run = 0; quiet = 0;
    exp_cols = 4'hE; exp_n = 4'h0; exp_init = 1'b0; exp_strobe = 1'b0;
  endtask

  // One clock of the model: rows reach decisions two clocks late; every SD-th clock is a sample.
  // mode 0 = looking, 1 = counting identical press samples, 2 = counting idle release samples
  task automatic model_step(input logic [3:0] r);
    logic [3:0] s;
    s = h1; h1 = h0; h0 = r;
    exp_strobe = 1'b0;
    if (cyc % SD == SD - 1) begin
      case (mode)
        0: if ($countones(~s) == 1) begin pat = s; run = 1; mode = 1; end
           else mcol = (mcol + 1) % 4;
        1: if (s == pat) begin
             run++;
             if (run == DC) begin
               mode = 2; quiet = 0;
               exp_n = 4'(km[low_row(pat)*4 + mcol]);
               exp_init = 1'b1; exp_strobe = 1'b1;
             end
           end else begin
             mode = 0; mcol = (mcol + 1) % 4;
           end
        default: if (s == 4'hF) begin
                   quiet++;
                   if (quiet == DC) begin mode = 0; mcol = (mcol + 1) % 4; end
                 end else quiet = 0;
      endcase
    end
    cyc++;
    exp_cols = 4'hF ^ (4'h1 << mcol);
  endtask

  // Advance one clock (negedge to negedge) and compare every output against the model
  task automatic tick();
    #1;
    if (!rst_n) model_reset();
    else model_step(rows);
    @(negedge clk);
    check("cycle", {cols, n, init, key_strobe}, {exp_cols, exp_n, exp_init, exp_strobe});
    if (key_strobe) strobes++;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    int s0, k;
    tbl[0] = '{16'h0000, 64, 4'h0, 1'b0, 0, 4'h0};
    tbl[1] = '{16'h0040, 40, 4'h6, 1'b1, 1, 4'hB};
    tbl[2] = '{16'h0011, 40, 4'h6, 1'b1, 0, 4'h0};
    tbl[3] = '{16'h0000, 8,  4'h6, 1'b1, 0, 4'h0};

    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_cols", {28'h0, cols}, 32'hE);
    check("reset_n_init_strobe", {26'h0, n, init, key_strobe}, 32'h0);
    ticks(3);
    rst_n = 1'b1;

    // Idle scan, press key 6, then release
    for (int t = 0; t < 2; t++) begin
      mask = tbl[t].mask; s0 = strobes;
      ticks(tbl[t].cycles);
      check("tbl_n", {28'h0, n}, {28'h0, tbl[t].n});
      check("tbl_init", {31'h0, init}, {31'h0, tbl[t].init});
      check("tbl_strobes", strobes - s0, tbl[t].strobes);
      if (tbl[t].cols != 4'h0) check("tbl_cols", {28'h0, cols}, {28'h0, tbl[t].cols});
    end

    mask = '0; s0 = strobes; k = 0;
    while (cols == 4'hB && k < 40) begin tick(); k++; end
    check("release_cols_resume", {28'h0, cols}, 32'h7);
    check("release_no_strobe", strobes - s0, 0);
    check("release_n_kept", {28'h0, n}, 32'h6);

    // Ghosting pattern and idle
    for (int t = 2; t < 4; t++) begin
      mask = tbl[t].mask; s0 = strobes;
      ticks(tbl[t].cycles);
      check("tbl_n", {28'h0, n}, {28'h0, tbl[t].n});
      check("tbl_init", {31'h0, init}, {31'h0, tbl[t].init});
      check("tbl_strobes", strobes - s0, tbl[t].strobes);
    end

    // Bounce on key '0' (row3, col1) at the second sample point
    k = 0;
    while (cols == 4'hD && k < 40) begin tick(); k++; end
    while (cols != 4'hD && k < 40) begin tick(); k++; end
    check("bounce_found_col1", {28'h0, cols}, 32'hD);
    s0 = strobes;
    mask = 16'h2000; ticks(5);
    mask = 16'h0000; ticks(3);
    check("bounce_rejected_cols", {28'h0, cols}, 32'hB);
    mask = 16'h2000; ticks(20);
    check("bounce_no_early_strobe", strobes - s0, 0);
    ticks(40);
    check("bounce_one_strobe", strobes - s0, 1);
    check("bounce_n", {28'h0, n}, 32'h0);
    mask = '0; ticks(30);

    // Async reset while key 'A' is held
    s0 = strobes;
    mask = 16'h0008; ticks(40);
    check("held_a_n", {28'h0, n}, 32'hA);
    check("held_a_strobe", strobes - s0, 1);
    check("held_a_cols", {28'h0, cols}, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cols", {28'h0, cols}, 32'hE);
    check("async_rst_outs", {26'h0, n, init, key_strobe}, 32'h0);
    mask = '0;
    ticks(3);
    rst_n = 1'b1;

    // Randomized presses, bounces and multi-key patterns
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 9));
      if (k < 6) mask = '0;
      else if (k < 9) mask = 16'h1 << $urandom_range(0, 15);
      else mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      ticks(int'($urandom_range(1, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
